// File: rtl/multi_ch_debouncer_if.sv
// rtl/multi_ch_debouncer_if.sv - signal bundle between raw inputs, debouncer and consumer logic
// Purpose: groups the enable, raw inputs and debounced outputs/pulses of multi_ch_debouncer.
// Ports (signals):
//   en           - 1 = debounce active, 0 = freeze outputs and clear counters
//   db_i         - raw asynchronous inputs, one bit per channel
//   db_o         - debounced levels
//   rise_o       - one-cycle pulse when db_o[n] goes 0->1
//   fall_o       - one-cycle pulse when db_o[n] goes 1->0
//   any_change_o - OR of all rise_o/fall_o bits in the same cycle
//   long_o       - one-cycle long-press pulse per channel
// Modports: master drives en/db_i and observes outputs; slave is the debouncer.
interface multi_ch_debouncer_if #(
  parameter int NUM_CH = 4
);
  logic              en;
  logic [NUM_CH-1:0] db_i;
  logic [NUM_CH-1:0] db_o;
  logic [NUM_CH-1:0] rise_o;
  logic [NUM_CH-1:0] fall_o;
  logic              any_change_o;
  logic [NUM_CH-1:0] long_o;

  modport master (
    output en, db_i,
    input  db_o, rise_o, fall_o, any_change_o, long_o
  );

  modport slave (
    input  en, db_i,
    output db_o, rise_o, fall_o, any_change_o, long_o
  );
endinterface

// File: rtl/multi_ch_debouncer.sv
// rtl/multi_ch_debouncer.sv - parametrised multi-channel debouncer with edge and long-press pulses
// Purpose: per channel, synchronise a raw input, require it to differ from the debounced
//   level for DB_CYCLES consecutive enabled cycles before adopting it, and emit registered
//   one-cycle rise/fall pulses. DB_CYCLES = (CLK_FREQ_HZ/1000000)*DEBOUNCE_US.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - multi_ch_debouncer_if.slave (en, db_i, db_o, rise_o, fall_o, any_change_o, long_o)
// Optional feature: define LONG_PRESS_EN to enable per-channel hold counters that pulse
//   long_o[n] once per press after HOLD_CYCLES enabled cycles of db_o[n]==1.
//   Without it long_o is tied to 0 and HOLD_US is ignored.
module multi_ch_debouncer #(
  parameter int NUM_CH      = 4,
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int DEBOUNCE_US = 10000,
  parameter int SYNC_STAGES = 2,
  parameter int RESET_LEVEL = 0,
  parameter int HOLD_US     = 1000000
) (
  input logic                 clk,
  input logic                 rst_n,
  multi_ch_debouncer_if.slave bus
);

  localparam int DB_CYCLES = (CLK_FREQ_HZ / 1000000) * DEBOUNCE_US;
  localparam int CNT_W     = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [NUM_CH-1:0] RST_VEC  = {NUM_CH{RESET_LEVEL != 0}};

  // Synchroniser: a plain flop chain per channel, last stage feeds the debounce logic.
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RST_VEC;
    end else begin
      sync_q[0] <= bus.db_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Stability counters and debounced state.
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] db_q, db_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic              any_q;

  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!bus.en || (s[c] == db_q[c])) begin
        // Any agreement (or a disabled cycle) restarts the stability window.
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CNT_LAST) begin
        db_d[c]   = s[c];
        cnt_d[c]  = '0;
        rise_d[c] = s[c];
        fall_d[c] = ~s[c];
      end else begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      db_q   <= RST_VEC;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= |(rise_d | fall_d);
    end
  end

  assign bus.db_o         = db_q;
  assign bus.rise_o       = rise_q;
  assign bus.fall_o       = fall_q;
  assign bus.any_change_o = any_q;

`ifdef LONG_PRESS_EN
  localparam int HOLD_CYCLES = (CLK_FREQ_HZ / 1000000) * HOLD_US;
  localparam int HOLD_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q [NUM_CH];
  logic [NUM_CH-1:0] long_q;

  // Hold counter saturates at HOLD_MAX, so the pulse fires only on the step into
  // saturation: one pulse per press. It freezes (not clears) while en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) hold_q[c] <= '0;
      long_q <= '0;
    end else begin
      long_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!db_q[c]) begin
          hold_q[c] <= '0;
        end else if (bus.en && (hold_q[c] != HOLD_MAX)) begin
          hold_q[c] <= hold_q[c] + 1'b1;
          long_q[c] <= (hold_q[c] == HOLD_PRE);
        end
      end
    end
  end

  assign bus.long_o = long_q;
`else
  assign bus.long_o = '0;
`endif

endmodule
